chacha_loader: RTL

Sequencer directly upstream of the ChaCha block core. Holds the host-programmed 256-bit key, 96-bit nonce and 32-bit block counter, then on `start` streams the full 64-byte initial ChaCha state into the core over its byte-write port. It waits for the core's `ready` to confirm that all 20 rounds have completed, and then signals `done`. Optionally it advances the block counter after each completed block.

---
 rtl/chacha_pkg.sv | 28 ++
 rtl/chacha_cfg_regs.sv | 68 ++++++
 rtl/chacha_loader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// Shared ChaCha loader definitions: sigma constant, state/config byte maps, round latency and FSM states.
package chacha_pkg;

  localparam logic [7:0] CHACHA_SIGMA [16] = '{
    8'h65, 8'h78, 8'h70, 8'h61, 8'h6e, 8'h64, 8'h20, 8'h33,
    8'h32, 8'h2d, 8'h62, 8'h79, 8'h74, 8'h65, 8'h20, 8'h6b
  };

  // Core state byte map
  localparam logic [5:0] KEY_BASE   = 6'd16;
  localparam logic [5:0] CTR_BASE   = 6'd48;
  localparam logic [5:0] NONCE_BASE = 6'd52;
  localparam logic [5:0] LAST_IDX   = 6'd63;

  // Host config byte map
  localparam logic [5:0] CFG_NONCE_BASE = 6'd32;
  localparam logic [5:0] CFG_CTR_BASE   = 6'd44;
  localparam logic [5:0] CFG_RSVD_BASE  = 6'd48;

  localparam int unsigned CHACHA_ROUND_CYCLES = 32'd160;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } chacha_state_e;

endpackage

// File: rtl/chacha_cfg_regs.sv
// Key/nonce/counter store in host config byte order, with a combinational read by core state address.
// CHACHA_LOADER_CTR_INC_EN adds the per-block counter increment port.
module chacha_cfg_regs
  import chacha_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
`ifdef CHACHA_LOADER_CTR_INC_EN
  input  logic       ctr_inc,
`endif
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0]  cfg_r [48];
  logic [5:0]  rd_idx_s;
  logic [31:0] ctr_s;
  logic [31:0] ctr_inc_s;

  assign ctr_s     = {cfg_r[47], cfg_r[46], cfg_r[45], cfg_r[44]};
  assign ctr_inc_s = ctr_s + 32'd1;

  // Config byte storage: host writes below the reserved range, optional counter advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_r <= '{default: 8'h00};
    end else begin
      if (we && (waddr < CFG_RSVD_BASE)) begin
        cfg_r[waddr] <= wdata;
      end
`ifdef CHACHA_LOADER_CTR_INC_EN
      if (ctr_inc) begin
        cfg_r[44] <= ctr_inc_s[7:0];
        cfg_r[45] <= ctr_inc_s[15:8];
        cfg_r[46] <= ctr_inc_s[23:16];
        cfg_r[47] <= ctr_inc_s[31:24];
      end
`endif
    end
  end

  // Core state address -> sigma constant or config byte (key and counter/nonce swap order)
  always_comb begin
    rd_idx_s = 6'd0;
    rd_data  = 8'h00;
    if (rd_addr < KEY_BASE) begin
      rd_data = CHACHA_SIGMA[rd_addr[3:0]];
    end else begin
      if (rd_addr < CTR_BASE) begin
        rd_idx_s = rd_addr - KEY_BASE;
      end else if (rd_addr < NONCE_BASE) begin
        rd_idx_s = rd_addr - (CTR_BASE - CFG_CTR_BASE);
      end else begin
        rd_idx_s = rd_addr - (NONCE_BASE - CFG_NONCE_BASE);
      end
      rd_data = cfg_r[rd_idx_s];
    end
  end

`ifndef CHACHA_LOADER_CTR_INC_EN
  logic unused_ctr_s;
  assign unused_ctr_s = ^ctr_inc_s;
`endif

endmodule

// File: rtl/chacha_loader.sv
// Streams the 64-byte ChaCha initial state into the block core, then waits for its ready flag.
// CHACHA_LOADER_CTR_INC_EN advances the block counter on every done.
module chacha_loader
  import chacha_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [5:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       blk_write,
  output logic [5:0] blk_addr,
  output logic [7:0] blk_data,
  input  logic       blk_ready
);

  chacha_state_e state_r, state_nxt_s;
  logic [5:0] idx_r, idx_nxt_s;
  logic       busy_r, done_r, blk_write_r;
  logic [5:0] blk_addr_r;
  logic [7:0] blk_data_r;

  logic       done_nxt_s, write_nxt_s;
  logic [5:0] addr_nxt_s, rd_addr_s;
  logic [7:0] data_nxt_s, rd_data_s;
  logic       cfg_we_s;

  assign cfg_we_s = cfg_we & ~busy_r;

  chacha_cfg_regs u_cfg_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we_s),
    .waddr   (cfg_addr),
    .wdata   (cfg_data),
`ifdef CHACHA_LOADER_CTR_INC_EN
    .ctr_inc (done_nxt_s),
`endif
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Next state, next byte index and next output values
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    rd_addr_s   = 6'd0;
    write_nxt_s = 1'b0;
    addr_nxt_s  = blk_addr_r;
    data_nxt_s  = blk_data_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
          idx_nxt_s   = 6'd0;
          rd_addr_s   = 6'd0;
          write_nxt_s = 1'b1;
          addr_nxt_s  = 6'd0;
          data_nxt_s  = rd_data_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = ST_WAIT;
        end else begin
          idx_nxt_s   = idx_r + 6'd1;
          rd_addr_s   = idx_r + 6'd1;
          write_nxt_s = 1'b1;
          addr_nxt_s  = idx_r + 6'd1;
          data_nxt_s  = rd_data_s;
        end
      end
      ST_WAIT: begin
        // Core drops ready on the first write edge, so a high here is this block's result
        if (blk_ready) begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, index and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= 6'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      blk_write_r <= 1'b0;
      blk_addr_r  <= 6'd0;
      blk_data_r  <= 8'h00;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      done_r      <= done_nxt_s;
      blk_write_r <= write_nxt_s;
      blk_addr_r  <= addr_nxt_s;
      blk_data_r  <= data_nxt_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign blk_write = blk_write_r;
  assign blk_addr  = blk_addr_r;
  assign blk_data  = blk_data_r;

endmodule
